ifid_buffer: RTL and testbench

- Fetch-to-decode pipeline buffer: the stage directly downstream of instruction fetch.
- Captures the {PC, nextPC, Ins} triple produced by fetch into a 2-entry skid queue and presents it to decode with a valid/ready handshake.
- Decouples fetch from decode stalls and supports a synchronous flush on branch/jump redirect.

---
 rtl/ifid_buffer.sv | 96 +++++++++
 tb/tb_ifid_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifid_buffer.sv
// Fetch-to-decode 2-entry skid buffer; one-cycle latency from f_* to d_*, no bypass.
// f_ready depends only on registered occupancy, flush beats push/pop; IFID_PERF_CNT_EN adds stall_cnt.
module ifid_buffer #(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   NOP_WORD = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          f_valid,
  input  logic [DW-1:0] f_pc,
  input  logic [DW-1:0] f_next_pc,
  input  logic [DW-1:0] f_ins,
  output logic          f_ready,
  output logic          d_valid,
  output logic [DW-1:0] d_pc,
  output logic [DW-1:0] d_next_pc,
  output logic [DW-1:0] d_ins,
  input  logic          d_ready,
  input  logic          flush,
  output logic [1:0]    occ
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] next_pc;
    logic [DW-1:0] ins;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Gating with RST drops f_ready the instant reset asserts, without waiting for an edge.
  assign f_ready = (count != 2'd2) & RST;
  assign d_valid = (count != 2'd0);
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;
  assign occ     = count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: f_pc, next_pc: f_next_pc, ins: f_ins};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stale entries stay hidden: an empty buffer always presents a NOP.
  always_comb begin
    d_pc      = '0;
    d_next_pc = '0;
    d_ins     = NOP_WORD;
    if (d_valid) begin
      d_pc      = mem[rd_ptr].pc;
      d_next_pc = mem[rd_ptr].next_pc;
      d_ins     = mem[rd_ptr].ins;
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (f_valid & ~f_ready & ~flush & (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_buffer.sv
// Scoreboard bench for ifid_buffer: a queue model tracks accepted triples and a negedge monitor compares.
// Directed cases from the test plan are followed by a randomized phase with flushes and async resets.
module tb_ifid_buffer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ins;
  } trip_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_next_pc;
  logic [31:0] f_ins;
  logic        f_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_next_pc;
  logic [31:0] d_ins;
  logic        d_ready;
  logic        flush;
  logic [1:0]  occ;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_stall;
`endif

  trip_t       mq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc_r;
  logic [31:0] ins_r;

  ifid_buffer #(.DW(32), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .RST(RST),
    .f_valid(f_valid), .f_pc(f_pc), .f_next_pc(f_next_pc), .f_ins(f_ins), .f_ready(f_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_next_pc(d_next_pc), .d_ins(d_ins), .d_ready(d_ready),
    .flush(flush), .occ(occ)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a bounded FIFO of at most two triples.
  always @(posedge CLK or negedge RST) begin
    bit can_push, can_pop;
    if (!RST) begin
      mq.delete();
`ifdef IFID_PERF_CNT_EN
      m_stall = 32'd0;
`endif
    end else begin
`ifdef IFID_PERF_CNT_EN
      if (f_valid && mq.size() == 2 && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        can_pop  = (mq.size() > 0) && d_ready;
        can_push = f_valid && (mq.size() < 2);
        if (can_pop) void'(mq.pop_front());
        if (can_push) mq.push_back({f_pc, f_next_pc, f_ins});
      end
    end
  end

  always @(negedge CLK) begin
    trip_t e;
    e = {32'd0, 32'd0, NOP};
    if (mq.size() > 0) e = mq[0];
    chk("occ", {30'd0, occ}, mq.size());
    chk("d_valid", {31'd0, d_valid}, {31'd0, mq.size() > 0});
    chk("f_ready", {31'd0, f_ready}, {31'd0, (mq.size() < 2) && RST});
    chk("d_pc", d_pc, e.pc);
    chk("d_next_pc", d_next_pc, e.npc);
    chk("d_ins", d_ins, e.ins);
`ifdef IFID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  end

  // One fetch/decode cycle; fetch advances only once its triple is accepted.
  task automatic cyc(input logic fv, input logic dr, input logic fl);
    bit acc;
    f_valid   = fv;
    d_ready   = dr;
    flush     = fl;
    f_pc      = pc_r;
    f_next_pc = pc_r + 32'd4;
    f_ins     = ins_r;
    acc = fv && !fl && (mq.size() < 2) && RST;
    @(posedge CLK);
    #2;
    if (acc) begin
      pc_r  = pc_r + 32'd4;
      ins_r = $urandom;
    end
  endtask

  initial begin
    RST = 1'b0; f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
    f_pc = '0; f_next_pc = '0; f_ins = '0;
    pc_r = 32'd0; ins_r = 32'h2002_0005;
    #1;
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_f_ready", {31'd0, f_ready}, 32'd0);
    chk("rst_d_ins", d_ins, NOP);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk("rel_f_ready", {31'd0, f_ready}, 32'd1);

    // First push right after reset release.
    cyc(1, 0, 0);
    chk("t1_d_valid", {31'd0, d_valid}, 32'd1);
    chk("t1_d_ins", d_ins, 32'h2002_0005);
    chk("t1_occ", {30'd0, occ}, 32'd1);
    chk("t1_f_ready", {31'd0, f_ready}, 32'd1);

    // Fill to full, hold off 0x8, then drain in order.
    cyc(0, 0, 1);
    pc_r = 32'd0;
    repeat (3) cyc(1, 0, 0);
    chk("t2_occ_full", {30'd0, occ}, 32'd2);
    chk("t2_f_ready", {31'd0, f_ready}, 32'd0);
    chk("t2_held_pc", pc_r, 32'd8);
    cyc(1, 1, 0);
    chk("t2_head_4", d_pc, 32'd4);
    cyc(1, 1, 0);
    chk("t2_head_8", d_pc, 32'd8);
    cyc(0, 1, 0);
    chk("t2_drained", {30'd0, occ}, 32'd0);

    // Streaming at occupancy 1.
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0);
      chk("t3_occ", {30'd0, occ}, 32'd1);
      chk("t3_d_pc", d_pc, 32'h10 + 32'd4 * i);
    end

    // Flush at full with a push and pop offered.
    cyc(1, 0, 0);
    chk("t4_occ_full", {30'd0, occ}, 32'd2);
    cyc(1, 1, 1);
    chk("t4_occ", {30'd0, occ}, 32'd0);
    chk("t4_d_valid", {31'd0, d_valid}, 32'd0);
    chk("t4_d_ins", d_ins, NOP);
    chk("t4_f_ready", {31'd0, f_ready}, 32'd1);
    pc_r = 32'h1000;
    cyc(0, 0, 0);
    chk("t4_no_ghost", {30'd0, occ}, 32'd0);
    repeat (3) cyc(1, 1, 1);
    chk("t4_multi_flush", {30'd0, occ}, 32'd0);

    // Asynchronous reset mid-cycle at full.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t5_occ_full", {30'd0, occ}, 32'd2);
    #1 RST = 1'b0;
    #1;
    chk("t5_d_valid", {31'd0, d_valid}, 32'd0);
    chk("t5_f_ready", {31'd0, f_ready}, 32'd0);
    chk("t5_occ", {30'd0, occ}, 32'd0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk("t5_rel_f_ready", {31'd0, f_ready}, 32'd1);

    // Stall counter: 5 edges offered while full.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(1, 0, 0);
`ifdef IFID_PERF_CNT_EN
    chk("t6_stall_5", stall_cnt, 32'd5);
    cyc(0, 0, 1);
    chk("t6_stall_flush", stall_cnt, 32'd5);
    #1 RST = 1'b0;
    #1 chk("t6_stall_rst", stall_cnt, 32'd0);
    @(posedge CLK);
    #2 RST = 1'b1;
`else
    cyc(0, 0, 1);
`endif

    // Randomized traffic with occasional redirects and resets.
    repeat (400) begin
      logic fv, dr, fl;
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 15) == 0);
      cyc(fv, dr, fl);
      if (fl) pc_r = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) begin
        #1 RST = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b1;
      end
    end

    cyc(0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
